// File: rtl/alu_ctrl_seq_if.sv
// alu_ctrl_seq_if: request/response bundle between ID-stage control, the ALU
// control sequencer and the ALU stage.
//   valid_in / instr / ALUOp / ready_out : request handshake from decode
//   valid_out / alu_func / stall_in      : result handshake toward the ALU
//   multi_busy                           : multi-cycle op in flight
// master = requester/consumer side, slave = the sequencer.
interface alu_ctrl_seq_if #(
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned OP_W    = 3
);
  logic               valid_in;
  logic [FUNCT_W-1:0] instr;
  logic [OP_W-1:0]    ALUOp;
  logic               ready_out;
  logic               stall_in;
  logic               valid_out;
  logic [FUNCT_W-1:0] alu_func;
  logic               multi_busy;

  modport master (
    output valid_in, instr, ALUOp, stall_in,
    input  ready_out, valid_out, alu_func, multi_busy
  );

  modport slave (
    input  valid_in, instr, ALUOp, stall_in,
    output ready_out, valid_out, alu_func, multi_busy
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decode with multi-cycle sequencing.
// Translates ALUOp + funct into the ALU function code, holds it under
// back-pressure and counts down LAT cycles for mult/div before presenting it.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : alu_ctrl_seq_if.slave (request in, ALU function out, multi_busy)
module alu_ctrl_seq #(
  parameter int unsigned        FUNCT_W   = 6,
  parameter int unsigned        OP_W      = 3,
  parameter int unsigned        LAT       = 4,
  parameter logic [FUNCT_W-1:0] MUL_FUNCT = FUNCT_W'(6'b011000),
  parameter logic [FUNCT_W-1:0] DIV_FUNCT = FUNCT_W'(6'b011010)
) (
  input logic            clk,
  input logic            reset,
  alu_ctrl_seq_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    OUT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FUNCT_W-1:0] alu_func_q, alu_func_d;
  logic               valid_out_q, valid_out_d;
  logic               multi_busy_q, multi_busy_d;

  logic [FUNCT_W-1:0] dec_func_c;
  logic               r_type_c;
  logic               multi_c;
  logic               ready_c;
  logic               accept_c;
  logic               load_c;

  // Decode; any nonzero ALUOp bit above bit 2 forces the R-type default.
  always_comb begin
    dec_func_c = bus.instr;
    r_type_c   = 1'b1;
    if ((bus.ALUOp >> 3) == '0) begin
      case (bus.ALUOp[2:0])
        3'b001: begin dec_func_c = '0;                   r_type_c = 1'b0; end
        3'b011: begin dec_func_c = FUNCT_W'(6'b100000);  r_type_c = 1'b0; end
        3'b100: begin dec_func_c = FUNCT_W'(6'b100001);  r_type_c = 1'b0; end
        3'b101: begin dec_func_c = FUNCT_W'(6'b100010);  r_type_c = 1'b0; end
        3'b110: begin dec_func_c = FUNCT_W'(6'b100011);  r_type_c = 1'b0; end
        default: ;
      endcase
    end
    multi_c = r_type_c && ((bus.instr == MUL_FUNCT) || (bus.instr == DIV_FUNCT));
  end

  // Ready is combinational so a consumed result can be replaced with no bubble.
  always_comb begin
    ready_c  = (state_q == IDLE) || ((state_q == OUT) && !bus.stall_in);
    accept_c = bus.valid_in && ready_c;
  end

  // Next-state / next-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_func_d = alu_func_q;
    load_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) load_c = 1'b1;
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = OUT;
      end
      OUT: begin
        if (!bus.stall_in) begin
          if (accept_c) load_c  = 1'b1;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_c) begin
      alu_func_d = dec_func_c;
      if (multi_c) begin
        state_d = BUSY;
        cnt_d   = CNT_W'(LAT - 1);
      end else begin
        state_d = OUT;
      end
    end

    valid_out_d  = (state_d == OUT);
    multi_busy_d = (state_d == BUSY);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      alu_func_q   <= '0;
      valid_out_q  <= 1'b0;
      multi_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_func_q   <= alu_func_d;
      valid_out_q  <= valid_out_d;
      multi_busy_q <= multi_busy_d;
    end
  end

  assign bus.ready_out  = ready_c;
  assign bus.valid_out  = valid_out_q;
  assign bus.alu_func   = alu_func_q;
  assign bus.multi_busy = multi_busy_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: scoreboard bench for alu_ctrl_seq. The driver pushes the
// expected function code and due cycle of every accepted request; a negedge
// monitor compares the DUT outputs against the queue head each cycle.
module tb_alu_ctrl_seq;

  localparam int unsigned FW  = 6;
  localparam int unsigned OW  = 3;
  localparam int unsigned LAT = 4;
  localparam logic [5:0] MUL_F = 6'b011000;
  localparam logic [5:0] DIV_F = 6'b011010;

  typedef struct {
    logic [5:0]  func;
    int unsigned due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [5:0] last_func = '0;
  exp_t q[$];

  alu_ctrl_seq_if #(.FUNCT_W(FW), .OP_W(OW)) bus ();

  alu_ctrl_seq #(
    .FUNCT_W(FW), .OP_W(OW), .LAT(LAT), .MUL_FUNCT(MUL_F), .DIV_FUNCT(DIV_F)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference decode straight from the op-class table.
  function automatic bit is_rtype(input logic [2:0] op);
    return !(op inside {3'b001, 3'b011, 3'b100, 3'b101, 3'b110});
  endfunction

  function automatic logic [5:0] ref_func(input logic [2:0] op, input logic [5:0] ins);
    case (op)
      3'b001:  return 6'd0;
      3'b011:  return 6'd32;
      3'b100:  return 6'd33;
      3'b101:  return 6'd34;
      3'b110:  return 6'd35;
      default: return ins;
    endcase
  endfunction

  function automatic bit ref_multi(input logic [2:0] op, input logic [5:0] ins);
    return is_rtype(op) && (ins == MUL_F || ins == DIV_F);
  endfunction

  // Monitor: the unit holds at most one op; classify by queue head and due cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (q.size() == 0) begin
        chk("idle_valid", 32'(bus.valid_out), 32'd0);
        chk("idle_ready", 32'(bus.ready_out), 32'd1);
        chk("idle_busy",  32'(bus.multi_busy), 32'd0);
        chk("idle_func",  32'(bus.alu_func), 32'(last_func));
      end else if (cyc < q[0].due) begin
        chk("busy_valid", 32'(bus.valid_out), 32'd0);
        chk("busy_ready", 32'(bus.ready_out), 32'd0);
        chk("busy_flag",  32'(bus.multi_busy), 32'd1);
      end else begin
        chk("out_valid", 32'(bus.valid_out), 32'd1);
        chk("out_func",  32'(bus.alu_func), 32'(q[0].func));
        chk("out_busy",  32'(bus.multi_busy), 32'd0);
        chk("out_ready", 32'(bus.ready_out), 32'(!bus.stall_in));
        if (!bus.stall_in) void'(q.pop_front());
      end
    end
  end

  task automatic step(input bit v, input logic [2:0] op, input logic [5:0] ins,
                      input bit st, output bit acc);
    exp_t e;
    bus.valid_in = v;
    bus.ALUOp    = op;
    bus.instr    = ins;
    bus.stall_in = st;
    @(negedge clk);
    acc = v && bus.ready_out;
    @(posedge clk);
    #1;
    if (acc) begin
      e.func = ref_func(op, ins);
      e.due  = cyc + (ref_multi(op, ins) ? LAT - 1 : 0);
      q.push_back(e);
      last_func = e.func;
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 3'b000, 6'd0, 1'b0, acc);
  endtask

  // Hold a request until accepted; stall_in is high for the first nstall tries.
  task automatic send(input logic [2:0] op, input logic [5:0] ins, input int nstall,
                      output int tries);
    bit acc = 1'b0;
    tries = 0;
    while (!acc) begin
      step(1'b1, op, ins, tries < nstall, acc);
      tries++;
      if (!acc && tries > 50) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: op %0b instr %0h not accepted", op, ins);
        break;
      end
    end
  endtask

  task automatic do_reset();
    bus.valid_in = 1'b0;
    bus.stall_in = 1'b0;
    reset = 1'b1;
    q.delete();
    last_func = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int t;
    bit acc;
    logic [2:0] ops[6] = '{3'b001, 3'b011, 3'b100, 3'b101, 3'b110, 3'b010};

    bus.valid_in = 1'b0;
    bus.instr    = '0;
    bus.ALUOp    = '0;
    bus.stall_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    // Decode sweep, back to back.
    foreach (ops[i]) begin
      send(ops[i], 6'b100100, 0, t);
      chk("sweep_tries", 32'(t), 32'd1);
    end
    idle(2);

    // Multiply occupancy.
    send(3'b010, MUL_F, 0, t);
    idle(LAT + 1);

    // Back-pressure: stall three cycles while the next request is held.
    send(3'b100, 6'd0, 0, t);
    send(3'b101, 6'd0, 3, t);
    chk("stall_accept_try", 32'(t), 32'd4);
    idle(2);

    // Reset one cycle after a div accept.
    send(3'b000, DIV_F, 0, t);
    idle(1);
    do_reset();
    idle(LAT + 2);

    // ldi class with div funct stays single-cycle.
    send(3'b011, DIV_F, 0, t);
    idle(2);

    // Mult then immediate back-to-back single op.
    send(3'b111, MUL_F, 0, t);
    send(3'b110, 6'd5, 0, t);
    idle(2);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      logic [5:0] ins;
      int r = $urandom_range(0, 7);
      ins = (r == 0) ? MUL_F : (r == 1) ? DIV_F : 6'($urandom);
      if ($urandom_range(0, 199) == 0) do_reset();
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), ins,
           $urandom_range(0, 3) == 0, acc);
    end
    idle(LAT + 2);
    chk("drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
